dti_apb_protocol_monitor: RTL and testbench

- Synthesizable, parametrised APB4 protocol monitor. It generalises the assertion-only APB checker to N slave selects and configurable address/data widths.
- Adds a wait-state timeout, per-rule error flags, and saturating error and transaction counters.
- Sits passively on an APB bus, in the bench or in silicon debug logic; never drives the bus.
- Results are exposed as pulse, sticky and count outputs, for a scoreboard or a CSR block to read.

---
 rtl/dti_apb_mon_pkg.sv | 20 ++
 rtl/dti_apb_sat_cnt.sv | 34 +++
 rtl/dti_apb_protocol_monitor.sv | 179 +++++++++++++++++
 tb/tb_dti_apb_protocol_monitor.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dti_apb_mon_pkg.sv
// rtl/dti_apb_mon_pkg.sv - shared FSM type and error bit indices for the APB protocol monitor
package dti_apb_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int ERR_SEL_ONEHOT      = 0;
    localparam int ERR_ENABLE_NO_SETUP = 1;
    localparam int ERR_SETUP_NO_ACCESS = 2;
    localparam int ERR_CTRL_UNSTABLE   = 3;
    localparam int ERR_WDATA_UNSTABLE  = 4;
    localparam int ERR_STRB_ON_READ    = 5;
    localparam int ERR_SEL_DROP        = 6;
    localparam int ERR_TIMEOUT         = 7;
    localparam int ERR_NUM             = 8;

endpackage

// File: rtl/dti_apb_sat_cnt.sv
// rtl/dti_apb_sat_cnt.sv - saturating counter; clr together with inc restarts the count at 1
module dti_apb_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? W'(1) : '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/dti_apb_protocol_monitor.sv
// rtl/dti_apb_protocol_monitor.sv - passive APB4 protocol monitor; DTI_APB_MON_COV_EN adds coverage counters
module dti_apb_protocol_monitor
    import dti_apb_mon_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_SLV     = 4,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [NUM_SLV-1:0]    PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_W-1:0]     PADDR,
    input  logic [DATA_W-1:0]     PWDATA,
    input  logic [DATA_W/8-1:0]   PSTRB,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    input  logic                  err_clr,
    output logic [ERR_NUM-1:0]    err_pulse,
    output logic [ERR_NUM-1:0]    err_sticky,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [CNT_W-1:0]      txn_cnt
`ifdef DTI_APB_MON_COV_EN
    ,
    output logic [CNT_W-1:0]      rd_cnt,
    output logic [CNT_W-1:0]      wr_cnt,
    output logic [CNT_W-1:0]      slverr_cnt,
    output logic [CNT_W-1:0]      wait_cnt
`endif
);

    localparam int WAIT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYC);

    apb_state_e             state_q, state_d;
    logic [ADDR_W-1:0]      cap_addr_q, cap_addr_d;
    logic                   cap_write_q, cap_write_d;
    logic [NUM_SLV-1:0]     cap_sel_q, cap_sel_d;
    logic [DATA_W-1:0]      cap_wdata_q, cap_wdata_d;
    logic [DATA_W/8-1:0]    cap_strb_q, cap_strb_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic                   to_fired_q, to_fired_d;
    logic [ERR_NUM-1:0]     err_pulse_q, err_pulse_d;
    logic [ERR_NUM-1:0]     err_sticky_q, err_sticky_d;
    logic [ERR_NUM-1:0]     err_vec;
    logic                   any_sel;
    logic                   capture;
    logic                   txn_inc;

    assign any_sel = |PSEL;

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        to_fired_d = to_fired_q;
        err_vec    = '0;
        capture    = 1'b0;
        txn_inc    = 1'b0;

        err_vec[ERR_SEL_ONEHOT]      = (PSEL & (PSEL - NUM_SLV'(1))) != '0;
        err_vec[ERR_ENABLE_NO_SETUP] = PENABLE && ((state_q == ST_IDLE) || !any_sel);
        err_vec[ERR_STRB_ON_READ]    = any_sel && !PWRITE && (PSTRB != '0);

        case (state_q)
            ST_IDLE: begin
                if (!PENABLE && any_sel) begin
                    state_d = ST_SETUP;
                    capture = 1'b1;
                end
            end
            ST_SETUP: begin
                if (PENABLE && (PSEL == cap_sel_q)) begin
                    state_d    = ST_ACCESS;
                    wait_d     = '0;
                    to_fired_d = 1'b0;
                end else begin
                    err_vec[ERR_SETUP_NO_ACCESS] = 1'b1;
                    if (!any_sel) begin
                        state_d = ST_IDLE;
                    end else begin
                        capture = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                err_vec[ERR_CTRL_UNSTABLE] = (PADDR != cap_addr_q) || (PWRITE != cap_write_q)
                                           || (PSEL != cap_sel_q);
                err_vec[ERR_WDATA_UNSTABLE] = cap_write_q
                                            && ((PWDATA != cap_wdata_q) || (PSTRB != cap_strb_q));
                // The wait counter parks at WAIT_MAX, so the fired flag keeps the timeout to one pulse.
                if ((TIMEOUT_CYC != 0) && (wait_q == WAIT_MAX) && !to_fired_q) begin
                    err_vec[ERR_TIMEOUT] = 1'b1;
                    to_fired_d           = 1'b1;
                end
                if (!any_sel) begin
                    err_vec[ERR_SEL_DROP] = 1'b1;
                    state_d               = ST_IDLE;
                end else if (PREADY) begin
                    txn_inc = 1'b1;
                    state_d = ST_IDLE;
                end else if (wait_q != WAIT_MAX) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cap_addr_d  = capture ? PADDR  : cap_addr_q;
        cap_write_d = capture ? PWRITE : cap_write_q;
        cap_sel_d   = capture ? PSEL   : cap_sel_q;
        cap_wdata_d = capture ? PWDATA : cap_wdata_q;
        cap_strb_d  = capture ? PSTRB  : cap_strb_q;

        err_pulse_d  = err_vec;
        err_sticky_d = err_clr ? err_vec : (err_sticky_q | err_vec);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q      <= ST_IDLE;
            cap_addr_q   <= '0;
            cap_write_q  <= 1'b0;
            cap_sel_q    <= '0;
            cap_wdata_q  <= '0;
            cap_strb_q   <= '0;
            wait_q       <= '0;
            to_fired_q   <= 1'b0;
            err_pulse_q  <= '0;
            err_sticky_q <= '0;
        end else begin
            state_q      <= state_d;
            cap_addr_q   <= cap_addr_d;
            cap_write_q  <= cap_write_d;
            cap_sel_q    <= cap_sel_d;
            cap_wdata_q  <= cap_wdata_d;
            cap_strb_q   <= cap_strb_d;
            wait_q       <= wait_d;
            to_fired_q   <= to_fired_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;

    dti_apb_sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk (PCLK), .rst (PRESET), .clr (err_clr), .inc (|err_vec), .cnt (err_cnt)
    );

    dti_apb_sat_cnt #(.W(CNT_W)) u_txn_cnt (
        .clk (PCLK), .rst (PRESET), .clr (1'b0), .inc (txn_inc), .cnt (txn_cnt)
    );

`ifdef DTI_APB_MON_COV_EN
    logic acc_wait;
    assign acc_wait = (state_q == ST_ACCESS) && any_sel && !PREADY;

    dti_apb_sat_cnt #(.W(CNT_W)) u_rd_cnt (
        .clk (PCLK), .rst (PRESET), .clr (1'b0), .inc (txn_inc && !cap_write_q), .cnt (rd_cnt)
    );
    dti_apb_sat_cnt #(.W(CNT_W)) u_wr_cnt (
        .clk (PCLK), .rst (PRESET), .clr (1'b0), .inc (txn_inc && cap_write_q), .cnt (wr_cnt)
    );
    dti_apb_sat_cnt #(.W(CNT_W)) u_slverr_cnt (
        .clk (PCLK), .rst (PRESET), .clr (1'b0), .inc (txn_inc && PSLVERR), .cnt (slverr_cnt)
    );
    dti_apb_sat_cnt #(.W(CNT_W)) u_wait_cnt (
        .clk (PCLK), .rst (PRESET), .clr (1'b0), .inc (acc_wait), .cnt (wait_cnt)
    );
`else
    logic unused_pslverr;
    assign unused_pslverr = PSLVERR;
`endif

endmodule

// File: tb/tb_dti_apb_protocol_monitor.sv
// tb/tb_dti_apb_protocol_monitor.sv - scoreboard bench for dti_apb_protocol_monitor
module tb_dti_apb_protocol_monitor;

    localparam int TIMEOUT = 16;
    localparam int CMAX    = 65535;
    localparam int P_IDLE = 0, P_SETUP = 1, P_ACCESS = 2;

    logic        PCLK = 1'b0;
    logic        PRESET, PENABLE, PWRITE, PREADY, PSLVERR, err_clr;
    logic [3:0]  PSEL, PSTRB;
    logic [31:0] PADDR, PWDATA;
    logic [7:0]  err_pulse, err_sticky;
    logic [15:0] err_cnt, txn_cnt;
`ifdef DTI_APB_MON_COV_EN
    logic [15:0] rd_cnt, wr_cnt, slverr_cnt, wait_cnt;
`endif

    dti_apb_protocol_monitor dut (
        .PCLK (PCLK), .PRESET (PRESET), .PSEL (PSEL), .PENABLE (PENABLE), .PWRITE (PWRITE),
        .PADDR (PADDR), .PWDATA (PWDATA), .PSTRB (PSTRB), .PREADY (PREADY), .PSLVERR (PSLVERR),
        .err_clr (err_clr), .err_pulse (err_pulse), .err_sticky (err_sticky),
        .err_cnt (err_cnt), .txn_cnt (txn_cnt)
`ifdef DTI_APB_MON_COV_EN
        , .rd_cnt (rd_cnt), .wr_cnt (wr_cnt), .slverr_cnt (slverr_cnt), .wait_cnt (wait_cnt)
`endif
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [7:0]  pulse;
        logic [7:0]  sticky;
        logic [15:0] ecnt;
        logic [15:0] tcnt;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0, n_fail = 0;
    int cyc = 0, n7 = 0, last7 = 0;

    // Reference model: one transfer record plus phase, advanced per sampled cycle
    int          m_phase, m_wait, m_errcnt, m_txn;
    bit          m_fired;
    logic [3:0]  m_sel, m_strb;
    logic [31:0] m_addr, m_wdata;
    logic        m_wr;
    logic [7:0]  m_sticky;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        logic [7:0] e = '0;
        bit cap = 0;
        bit done = 0;
        exp_t x;
        if (PRESET) begin
            m_phase = P_IDLE; m_wait = 0; m_fired = 0; m_errcnt = 0; m_txn = 0;
            m_sel = '0; m_strb = '0; m_addr = '0; m_wdata = '0; m_wr = 0; m_sticky = '0;
        end else begin
            e[0] = $countones(PSEL) > 1;
            e[1] = PENABLE && (m_phase == P_IDLE || PSEL == 0);
            e[5] = PSEL != 0 && !PWRITE && PSTRB != 0;
            if (m_phase == P_ACCESS) begin
                e[3] = PADDR != m_addr || PWRITE != m_wr || PSEL != m_sel;
                e[4] = m_wr && (PWDATA != m_wdata || PSTRB != m_strb);
                e[7] = m_wait == TIMEOUT && !m_fired;
                if (e[7]) m_fired = 1;
            end
            case (m_phase)
                P_IDLE: if (!PENABLE && PSEL != 0) begin m_phase = P_SETUP; cap = 1; end
                P_SETUP: begin
                    if (PENABLE && PSEL == m_sel) begin
                        m_phase = P_ACCESS; m_wait = 0; m_fired = 0;
                    end else begin
                        e[2] = 1;
                        if (PSEL == 0) m_phase = P_IDLE;
                        else cap = 1;
                    end
                end
                default: begin
                    if (PSEL == 0) begin e[6] = 1; m_phase = P_IDLE; end
                    else if (PREADY) begin done = 1; m_phase = P_IDLE; end
                    else if (m_wait < TIMEOUT) m_wait++;
                end
            endcase
            if (cap) begin
                m_sel = PSEL; m_addr = PADDR; m_wr = PWRITE; m_wdata = PWDATA; m_strb = PSTRB;
            end
            if (done && m_txn < CMAX) m_txn++;
            if (err_clr) begin
                m_sticky = e;
                m_errcnt = (e != 0) ? 1 : 0;
            end else begin
                m_sticky = m_sticky | e;
                if (e != 0 && m_errcnt < CMAX) m_errcnt++;
            end
        end
        x.pulse  = PRESET ? 8'h00 : e;
        x.sticky = m_sticky;
        x.ecnt   = m_errcnt[15:0];
        x.tcnt   = m_txn[15:0];
        sb.push_back(x);
    endtask

    // Model the current inputs, then let the clock edge consume them
    task automatic tick();
        model_step();
        @(posedge PCLK);
        #2;
    endtask

    task automatic drive(input logic [3:0] sel, input logic en, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb, input logic rdy);
        PSEL = sel; PENABLE = en; PWRITE = wr; PADDR = addr; PWDATA = wd; PSTRB = strb;
        PREADY = rdy; PSLVERR = 1'b0; err_clr = 1'b0; PRESET = 1'b0;
    endtask

    task automatic idle();
        drive(4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        tick();
    endtask

    task automatic do_reset();
        drive(4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        PRESET = 1'b1;
        tick();
        tick();
        PRESET = 1'b0;
    endtask

    task automatic rnd_glitch();
        if ($urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 4))
                0: PSEL = 4'($urandom());
                1: PENABLE = ~PENABLE;
                2: PADDR = $urandom();
                3: PWDATA = $urandom();
                default: PSTRB = 4'($urandom());
            endcase
        end
        err_clr = ($urandom_range(0, 15) == 0);
        PSLVERR = 1'($urandom());
        PRESET  = ($urandom_range(0, 99) == 0);
    endtask

    task automatic xfer(input logic [3:0] sel, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] strb, input int waits,
                        input bit glitch);
        drive(sel, 1'b0, wr, addr, wd, strb, 1'b0);
        if (glitch) rnd_glitch();
        tick();
        for (int i = 0; i < waits; i++) begin
            drive(sel, 1'b1, wr, addr, wd, strb, 1'b0);
            if (glitch) rnd_glitch();
            tick();
        end
        drive(sel, 1'b1, wr, addr, wd, strb, 1'b1);
        if (glitch) rnd_glitch();
        tick();
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge PCLK);
            #1;
            cyc++;
            if (err_pulse[7]) begin n7++; last7 = cyc; end
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("err_pulse", err_pulse, x.pulse);
                chk("err_sticky", err_sticky, x.sticky);
                chk("err_cnt", err_cnt, x.ecnt);
                chk("txn_cnt", txn_cnt, x.tcnt);
            end
        end
    end

    initial begin : stimulus
        int entry, n7_0;
        logic [3:0] rs;
        logic rw;
        do_reset();
        chk("reset_err_sticky", err_sticky, 8'h00);
        chk("reset_txn_cnt", txn_cnt, 16'h0);

        xfer(4'b0010, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 2, 0);
        chk("write_txn_cnt", txn_cnt, 16'd1);
        chk("write_err_sticky", err_sticky, 8'h00);
        idle();

        drive(4'b0011, 1'b0, 1'b1, 32'h20, 32'h0, 4'h0, 1'b0);
        tick();
        chk("multisel_pulse", err_pulse, 8'h01);
        chk("multisel_err_cnt", err_cnt, 16'd1);
        idle();
        idle();

        do_reset();
        drive(4'b0010, 1'b0, 1'b1, 32'h10, 32'h1234, 4'hF, 1'b0); tick();
        drive(4'b0010, 1'b1, 1'b1, 32'h10, 32'h1234, 4'hF, 1'b0); tick();
        drive(4'b0010, 1'b1, 1'b1, 32'h14, 32'h1234, 4'hF, 1'b0); tick();
        chk("addr_change_pulse", err_pulse, 8'h08);
        drive(4'b0010, 1'b1, 1'b1, 32'h14, 32'h1234, 4'hF, 1'b1); tick();
        chk("addr_change_txn_cnt", txn_cnt, 16'd1);
        idle();

        do_reset();
        xfer(4'b0001, 1'b0, 32'h30, 32'h0, 4'hF, 0, 0);
        chk("read_strb_sticky", err_sticky, 8'h20);
        idle();
        err_clr = 1'b1; tick();
        chk("clr_sticky", err_sticky, 8'h00);
        chk("clr_err_cnt", err_cnt, 16'd0);
        drive(4'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0); tick(); tick();
        err_clr = 1'b1; tick();
        chk("clr_with_err_sticky", err_sticky, 8'h02);
        chk("clr_with_err_cnt", err_cnt, 16'd1);
        idle();

        do_reset();
        drive(4'b0100, 1'b0, 1'b1, 32'h40, 32'hBEEF, 4'h3, 1'b0); tick();
        drive(4'b0100, 1'b1, 1'b1, 32'h40, 32'hBEEF, 4'h3, 1'b0); tick();
        entry = cyc;
        n7_0 = n7;
        for (int i = 0; i < 20; i++) tick();
        chk("timeout_pulse_count", n7 - n7_0, 1);
        chk("timeout_pulse_delay", last7 - entry, 17);
        PREADY = 1'b1; tick();
        idle();

        drive(4'b1000, 1'b0, 1'b0, 32'h50, 32'h0, 4'h0, 1'b0); tick();
        drive(4'b1000, 1'b1, 1'b0, 32'h50, 32'h0, 4'h0, 1'b0); tick();
        PRESET = 1'b1; tick();
        chk("midreset_pulse", err_pulse, 8'h00);
        chk("midreset_sticky", err_sticky, 8'h00);
        chk("midreset_err_cnt", err_cnt, 16'd0);
        chk("midreset_txn_cnt", txn_cnt, 16'd0);
        idle();
        xfer(4'b0001, 1'b1, 32'h60, 32'h55AA, 4'h1, 1, 0);
        chk("post_reset_txn_cnt", txn_cnt, 16'd1);
        chk("post_reset_sticky", err_sticky, 8'h00);

        for (int t = 0; t < 60; t++) begin
            rs = 4'b0001 << $urandom_range(0, 3);
            rw = 1'($urandom());
            xfer(rs, rw, $urandom(), $urandom(), rw ? 4'($urandom()) : 4'h0,
                 ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 3), 1);
            if ($urandom_range(0, 1) == 0) idle();
        end
        for (int t = 0; t < 150; t++) begin
            drive(4'($urandom()), 1'($urandom()), 1'($urandom()), 32'($urandom_range(0, 3)),
                  32'($urandom_range(0, 3)), 4'($urandom()), 1'($urandom()));
            err_clr = ($urandom_range(0, 7) == 0);
            PRESET  = ($urandom_range(0, 49) == 0);
            tick();
        end
        idle();
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
